// File: rtl/data_io_sync.sv
`default_nettype none
// ============================================================================
// Module      : data_io_sync
// Description : SPI slave (mode 0) for the board MCU. Oversamples the SPI pins
//               in the core clock domain, decodes status/config/index/readback
//               commands and streams ROM download bytes through a FIFO to the
//               ioctl write port under ioctl_wait back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module data_io_sync #(
    parameter int AW        = 26,
    parameter int CFG_BYTES = 16,
    parameter int STATUS_W  = 32,
    parameter int FIFO_AW   = 4,
    parameter int CONF_AW   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   SPI_SCK,
    input  logic                   SPI_SS2,
    input  logic                   SPI_DI,
    output logic                   SPI_DO,
    output logic                   SPI_DO_en,
    input  logic [7:0]             data_in,
    output logic [CONF_AW-1:0]     conf_addr,
    input  logic [7:0]             conf_chr,
    output logic [STATUS_W-1:0]    status,
    output logic [6:0]             core_mod,
    output logic [8*CFG_BYTES-1:0] config_buffer,
    output logic                   ioctl_download,
    output logic [7:0]             ioctl_index,
    output logic                   ioctl_wr,
    output logic [AW-1:0]          ioctl_addr,
    output logic [7:0]             ioctl_dout,
    input  logic                   ioctl_wait,
    output logic                   ioctl_ovf
);

    localparam int         STATUS_BYTES = STATUS_W / 8;
    localparam int         FIFO_DEPTH   = 1 << FIFO_AW;
    localparam logic [7:0] CMD_ID       = 8'h00;
    localparam logic [7:0] CMD_DATA_IN  = 8'h10;
    localparam logic [7:0] CMD_CONF_RD  = 8'h14;
    localparam logic [7:0] CMD_STATUS   = 8'h15;
    localparam logic [7:0] CMD_INDEX    = 8'h55;
    localparam logic [7:0] CMD_CONFIG   = 8'h60;
    localparam logic [7:0] CMD_DL_START = 8'h61;
    localparam logic [7:0] CMD_DL_END   = 8'h62;
    localparam logic [7:0] ID_BYTE      = 8'h4B;

    // ---------------- input synchronisers ----------------
    logic [2:0] sck_q;      // [1] synced, [2] previous synced value
    logic [1:0] ss_q;
    logic [1:0] di_q;

    // Two-flop synchronisers plus one history flop on SCK for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_q <= 3'b000;
            ss_q  <= 2'b11;
            di_q  <= 2'b00;
        end else begin
            sck_q <= {sck_q[1:0], SPI_SCK};
            ss_q  <= {ss_q[0], SPI_SS2};
            di_q  <= {di_q[0], SPI_DI};
        end
    end

    logic sck_rise, sck_fall, ss_idle;
    assign ss_idle  = ss_q[1];
    assign sck_rise = sck_q[1] & ~sck_q[2] & ~ss_idle;
    assign sck_fall = ~sck_q[1] & sck_q[2] & ~ss_idle;

    // ---------------- receive path ----------------
    logic [2:0] bit_cnt_q;
    logic [7:0] byte_cnt_q;   // saturating; 0 = command byte
    logic [6:0] sr_q;
    logic [7:0] cmd_q;
    logic [7:0] rx_byte_d;
    logic [7:0] data_idx_d;
    logic       byte_done_d, cmd_done_d, data_done_d;

    assign rx_byte_d   = {sr_q, di_q[1]};
    assign byte_done_d = sck_rise && (bit_cnt_q == 3'd7);
    assign cmd_done_d  = byte_done_d && (byte_cnt_q == 8'd0);
    assign data_done_d = byte_done_d && (byte_cnt_q != 8'd0);
    assign data_idx_d  = byte_cnt_q - 8'd1;

    // Bit/byte counting and command capture; SS2 high aborts any partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            sr_q       <= 7'd0;
            cmd_q      <= 8'd0;
        end else if (ss_idle) begin
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 8'd0;
            cmd_q      <= 8'd0;
        end else if (sck_rise) begin
            sr_q      <= rx_byte_d[6:0];
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (byte_done_d && byte_cnt_q != 8'hFF)
                byte_cnt_q <= byte_cnt_q + 8'd1;
            if (cmd_done_d)
                cmd_q <= rx_byte_d;
        end
    end

    // Register-file style commands: status word, core variant, config bytes, index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status        <= '0;
            core_mod      <= 7'd0;
            config_buffer <= '0;
            ioctl_index   <= 8'd0;
        end else if (data_done_d) begin
            case (cmd_q)
                CMD_STATUS: begin
                    for (int k = 0; k < STATUS_BYTES; k++)
                        if (data_idx_d == 8'(k))
                            status[STATUS_W-1-8*k -: 8] <= rx_byte_d;
                    if (data_idx_d == 8'(STATUS_BYTES))
                        core_mod <= rx_byte_d[6:0];
                end
                CMD_CONFIG: begin
                    for (int k = 0; k < CFG_BYTES; k++)
                        if (data_idx_d == 8'(k))
                            config_buffer[8*(CFG_BYTES-1-k) +: 8] <= rx_byte_d;
                end
                CMD_INDEX: ioctl_index <= rx_byte_d;
                default: ;
            endcase
        end
    end

    // ---------------- transmit path ----------------
    logic [7:0] tx_byte_d;
    logic [7:0] tx_sr_q;

    always_comb begin
        tx_byte_d = 8'd0;
        case (cmd_q)
            CMD_ID:      tx_byte_d = ID_BYTE;
            CMD_DATA_IN: tx_byte_d = data_in;
            CMD_CONF_RD: tx_byte_d = conf_chr;
            default:     tx_byte_d = 8'd0;
        endcase
    end

    // MISO shifter: the fall that begins a new byte (bit count 0) loads the reply
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            SPI_DO    <= 1'b0;
            SPI_DO_en <= 1'b0;
            tx_sr_q   <= 8'd0;
            conf_addr <= '0;
        end else begin
            SPI_DO_en <= ~ss_idle;
            if (ss_idle) begin
                SPI_DO    <= 1'b0;
                tx_sr_q   <= 8'd0;
                conf_addr <= '0;
            end else begin
                if (sck_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        SPI_DO  <= tx_byte_d[7];
                        tx_sr_q <= {tx_byte_d[6:0], 1'b0};
                    end else begin
                        SPI_DO  <= tx_sr_q[7];
                        tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                    end
                end
                // Bit 0 of the reply has gone out by the time its byte completes
                if (data_done_d && cmd_q == CMD_CONF_RD)
                    conf_addr <= conf_addr + 1'b1;
            end
        end
    end

    // ---------------- download FIFO ----------------
    logic [7:0]     mem_q [FIFO_DEPTH];
    logic [FIFO_AW:0] wptr_q, rptr_q;
    logic [AW-1:0]  addr_cnt_q;
    logic           end_pend_q;
    logic           fifo_empty_d, fifo_full_d, push_d, pop_d, flush_d, dl_end_d;

    assign fifo_empty_d = (wptr_q == rptr_q);
    assign fifo_full_d  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                          (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
    assign flush_d      = cmd_done_d && (rx_byte_d == CMD_DL_START);
    assign dl_end_d     = cmd_done_d && (rx_byte_d == CMD_DL_END);
    // Blocking on the previous strobe spaces strobes at least two cycles apart
    assign pop_d        = !fifo_empty_d && !ioctl_wait && !ioctl_wr && !flush_d;
    assign push_d       = data_done_d && (cmd_q == CMD_DL_START) &&
                          (!fifo_full_d || pop_d);

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk) begin
        if (push_d)
            mem_q[wptr_q[FIFO_AW-1:0]] <= rx_byte_d;
    end

    // FIFO pointers, write strobe generation, download state and overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q         <= '0;
            rptr_q         <= '0;
            addr_cnt_q     <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            ioctl_dout     <= 8'd0;
            ioctl_download <= 1'b0;
            ioctl_ovf      <= 1'b0;
            end_pend_q     <= 1'b0;
        end else begin
            ioctl_wr <= pop_d;
            if (push_d)
                wptr_q <= wptr_q + 1'b1;
            if (flush_d) begin
                rptr_q         <= wptr_q;
                addr_cnt_q     <= '0;
                ioctl_download <= 1'b1;
                ioctl_ovf      <= 1'b0;
                end_pend_q     <= 1'b0;
            end else if (pop_d) begin
                rptr_q     <= rptr_q + 1'b1;
                ioctl_dout <= mem_q[rptr_q[FIFO_AW-1:0]];
                ioctl_addr <= addr_cnt_q;
                addr_cnt_q <= addr_cnt_q + 1'b1;
            end
            if (data_done_d && cmd_q == CMD_DL_START && fifo_full_d && !pop_d)
                ioctl_ovf <= 1'b1;
            if (dl_end_d)
                end_pend_q <= 1'b1;
            else if (end_pend_q && fifo_empty_d && !pop_d && !ioctl_wr) begin
                end_pend_q     <= 1'b0;
                ioctl_download <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_io_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_io_sync
// Description : Directed self-checking bench for data_io_sync.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_io_sync;

    localparam int AW        = 26;
    localparam int CFG_BYTES = 16;
    localparam int STATUS_W  = 32;
    localparam int FIFO_AW   = 4;
    localparam int CONF_AW   = 10;
    localparam int HALF      = 60;   // SCK half period; clk period is 10

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   SPI_SCK = 1'b0;
    logic                   SPI_SS2 = 1'b1;
    logic                   SPI_DI = 1'b0;
    logic                   SPI_DO, SPI_DO_en;
    logic [7:0]             data_in = 8'h00;
    logic [CONF_AW-1:0]     conf_addr;
    logic [7:0]             conf_chr;
    logic [STATUS_W-1:0]    status;
    logic [6:0]             core_mod;
    logic [8*CFG_BYTES-1:0] config_buffer;
    logic                   ioctl_download;
    logic [7:0]             ioctl_index;
    logic                   ioctl_wr;
    logic [AW-1:0]          ioctl_addr;
    logic [7:0]             ioctl_dout;
    logic                   ioctl_wait = 1'b0;
    logic                   ioctl_ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    assign conf_chr = 8'h40 + conf_addr[7:0];

    data_io_sync #(
        .AW(AW), .CFG_BYTES(CFG_BYTES), .STATUS_W(STATUS_W),
        .FIFO_AW(FIFO_AW), .CONF_AW(CONF_AW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .SPI_SCK(SPI_SCK), .SPI_SS2(SPI_SS2), .SPI_DI(SPI_DI),
        .SPI_DO(SPI_DO), .SPI_DO_en(SPI_DO_en),
        .data_in(data_in), .conf_addr(conf_addr), .conf_chr(conf_chr),
        .status(status), .core_mod(core_mod), .config_buffer(config_buffer),
        .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wait(ioctl_wait), .ioctl_ovf(ioctl_ovf)
    );

    // Strobe recorder: one entry per ioctl_wr pulse, plus back-to-back detection
    logic [AW-1:0] q_addr [$];
    logic [7:0]    q_dout [$];
    int            gap_viol = 0;
    logic          prev_wr = 1'b0;
    always @(negedge clk) begin
        if (rst_n && ioctl_wr) begin
            q_addr.push_back(ioctl_addr);
            q_dout.push_back(ioctl_dout);
            if (prev_wr) gap_viol++;
        end
        prev_wr = ioctl_wr;
    end

    task automatic spi_start();
        @(negedge clk);
        SPI_SS2 = 1'b0;
        #HALF;
    endtask

    task automatic spi_end();
        #HALF;
        SPI_SS2 = 1'b1;
        repeat (8) @(posedge clk);
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            SPI_DI = tx[i];
            #HALF;
            rx[i] = SPI_DO;
            SPI_SCK = 1'b1;
            #HALF;
            SPI_SCK = 1'b0;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if ({ioctl_wr, ioctl_download, ioctl_ovf, SPI_DO, SPI_DO_en} !== 5'b0 ||
            status !== '0 || config_buffer !== '0 || core_mod !== 7'd0 ||
            ioctl_index !== 8'd0 || ioctl_addr !== '0 || ioctl_dout !== 8'd0 ||
            conf_addr !== '0) begin
            $display("FAIL reset_state: outputs not all zero (status=%h wr=%b dl=%b en=%b)",
                     status, ioctl_wr, ioctl_download, SPI_DO_en);
            err_cnt++;
        end
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_status();
        logic [7:0] rx;
        logic [7:0] tx [6] = '{8'h15, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h05};
        spi_start();
        for (int i = 0; i < 6; i++) spi_byte(tx[i], rx);
        spi_byte(8'h77, rx);   // beyond core_mod: must be ignored
        spi_end();
        vec_cnt++;
        if (status !== 32'hAABBCCDD) begin
            $display("FAIL status_word: got %h want AABBCCDD", status);
            err_cnt++;
        end
        vec_cnt++;
        if (core_mod !== 7'h05) begin
            $display("FAIL core_mod: got %h want 05", core_mod);
            err_cnt++;
        end
    endtask

    task automatic test_config();
        logic [7:0] rx;
        logic [8*CFG_BYTES-1:0] exp_cfg;
        exp_cfg = '0;
        exp_cfg[127:120] = 8'h11;
        exp_cfg[119:112] = 8'h22;
        spi_start();
        spi_byte(8'h60, rx);
        spi_byte(8'h11, rx);
        spi_byte(8'h22, rx);
        spi_end();
        vec_cnt++;
        if (config_buffer !== exp_cfg) begin
            $display("FAIL config_buffer: got %h want %h", config_buffer, exp_cfg);
            err_cnt++;
        end
    endtask

    task automatic test_index();
        logic [7:0] rx;
        spi_start();
        spi_byte(8'h55, rx);
        spi_byte(8'h03, rx);
        spi_byte(8'h07, rx);
        spi_end();
        vec_cnt++;
        if (ioctl_index !== 8'h07) begin
            $display("FAIL ioctl_index: got %h want 07", ioctl_index);
            err_cnt++;
        end
    endtask

    task automatic test_conf_read();
        logic [7:0] rx;
        logic [7:0] exp_rx [3] = '{8'h40, 8'h41, 8'h42};
        spi_start();
        vec_cnt++;
        if (SPI_DO_en !== 1'b1) begin
            $display("FAIL do_en_active: got %b want 1", SPI_DO_en);
            err_cnt++;
        end
        spi_byte(8'h14, rx);
        for (int i = 0; i < 3; i++) begin
            spi_byte(8'h00, rx);
            vec_cnt++;
            if (rx !== exp_rx[i]) begin
                $display("FAIL conf_miso[%0d]: got %h want %h", i, rx, exp_rx[i]);
                err_cnt++;
            end
        end
        #HALF;
        vec_cnt++;
        if (conf_addr !== 10'd3) begin
            $display("FAIL conf_addr_end: got %0d want 3", conf_addr);
            err_cnt++;
        end
        spi_end();
        vec_cnt++;
        if (conf_addr !== 10'd0 || SPI_DO_en !== 1'b0) begin
            $display("FAIL conf_idle: conf_addr=%0d do_en=%b want 0/0", conf_addr, SPI_DO_en);
            err_cnt++;
        end
    endtask

    task automatic test_data_in();
        logic [7:0] rx;
        data_in = 8'hA5;
        spi_start();
        spi_byte(8'h10, rx);
        spi_byte(8'h00, rx);
        spi_end();
        vec_cnt++;
        if (rx !== 8'hA5) begin
            $display("FAIL data_in_miso: got %h want A5", rx);
            err_cnt++;
        end
    endtask

    task automatic test_download();
        logic [7:0] rx;
        q_addr.delete(); q_dout.delete(); gap_viol = 0;
        ioctl_wait = 1'b0;
        spi_start();
        spi_byte(8'h61, rx);
        #HALF;
        vec_cnt++;
        if (ioctl_download !== 1'b1) begin
            $display("FAIL download_start: got %b want 1", ioctl_download);
            err_cnt++;
        end
        for (int i = 0; i < 20; i++) spi_byte(8'(i), rx);
        spi_end();
        repeat (40) @(posedge clk);
        vec_cnt++;
        if (q_addr.size() != 20) begin
            $display("FAIL download_count: got %0d want 20", q_addr.size());
            err_cnt++;
        end else begin
            for (int i = 0; i < 20; i++) begin
                vec_cnt++;
                if (q_addr[i] !== AW'(i) || q_dout[i] !== 8'(i)) begin
                    $display("FAIL download_strobe[%0d]: addr=%0d dout=%h want %0d/%h",
                             i, q_addr[i], q_dout[i], i, 8'(i));
                    err_cnt++;
                end
            end
        end
        vec_cnt++;
        if (gap_viol != 0 || ioctl_ovf !== 1'b0) begin
            $display("FAIL download_spacing: b2b=%0d ovf=%b want 0/0", gap_viol, ioctl_ovf);
            err_cnt++;
        end
        spi_start();
        spi_byte(8'h62, rx);
        spi_end();
        vec_cnt++;
        if (ioctl_download !== 1'b0) begin
            $display("FAIL download_end: got %b want 0", ioctl_download);
            err_cnt++;
        end
    endtask

    task automatic test_overflow();
        logic [7:0] rx;
        q_addr.delete(); q_dout.delete();
        ioctl_wait = 1'b1;
        spi_start();
        spi_byte(8'h61, rx);
        for (int i = 0; i < 20; i++) spi_byte(8'(100 + i), rx);
        spi_end();
        repeat (20) @(posedge clk);
        @(negedge clk);
        vec_cnt++;
        if (ioctl_ovf !== 1'b1 || q_addr.size() != 0) begin
            $display("FAIL ovf_hold: ovf=%b strobes=%0d want 1/0", ioctl_ovf, q_addr.size());
            err_cnt++;
        end
        ioctl_wait = 1'b0;
        repeat (60) @(posedge clk);
        vec_cnt++;
        if (q_addr.size() != 16) begin
            $display("FAIL ovf_drain_count: got %0d want 16", q_addr.size());
            err_cnt++;
        end else begin
            for (int i = 0; i < 16; i++) begin
                vec_cnt++;
                if (q_addr[i] !== AW'(i) || q_dout[i] !== 8'(100 + i)) begin
                    $display("FAIL ovf_drain[%0d]: addr=%0d dout=%h want %0d/%h",
                             i, q_addr[i], q_dout[i], i, 8'(100 + i));
                    err_cnt++;
                end
            end
        end
        spi_start();
        spi_byte(8'h62, rx);
        spi_end();
    endtask

    task automatic test_reset_mid_stream();
        logic [7:0] rx;
        spi_start();
        spi_byte(8'h00, rx);
        for (int i = 0; i < 2; i++) begin
            spi_byte(8'h00, rx);
            vec_cnt++;
            if (rx !== 8'h4B) begin
                $display("FAIL id_miso[%0d]: got %h want 4B", i, rx);
                err_cnt++;
            end
        end
        spi_end();
        q_addr.delete(); q_dout.delete();
        ioctl_wait = 1'b1;
        spi_start();
        spi_byte(8'h61, rx);
        for (int i = 0; i < 3; i++) spi_byte(8'hE0 + 8'(i), rx);
        for (int i = 0; i < 3; i++) begin   // part of a fourth byte
            SPI_DI = 1'b1;
            #HALF; SPI_SCK = 1'b1;
            #HALF; SPI_SCK = 1'b0;
        end
        #HALF;
        vec_cnt++;
        if (ioctl_download !== 1'b1 || SPI_DO_en !== 1'b1) begin
            $display("FAIL pre_reset: dl=%b do_en=%b want 1/1", ioctl_download, SPI_DO_en);
            err_cnt++;
        end
        #3 rst_n = 1'b0;
        #1;
        vec_cnt++;
        if ({ioctl_wr, ioctl_download, ioctl_ovf, SPI_DO, SPI_DO_en} !== 5'b0 ||
            status !== '0 || config_buffer !== '0 || core_mod !== 7'd0 ||
            ioctl_index !== 8'd0 || ioctl_addr !== '0 || ioctl_dout !== 8'd0) begin
            $display("FAIL async_reset: status=%h idx=%h dl=%b en=%b want all 0",
                     status, ioctl_index, ioctl_download, SPI_DO_en);
            err_cnt++;
        end
        SPI_SS2 = 1'b1;
        SPI_SCK = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ioctl_wait = 1'b0;
        repeat (60) @(posedge clk);
        vec_cnt++;
        if (q_addr.size() != 0 || ioctl_download !== 1'b0) begin
            $display("FAIL post_reset: strobes=%0d dl=%b want 0/0", q_addr.size(), ioctl_download);
            err_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_status();
        test_config();
        test_index();
        test_conf_read();
        test_data_in();
        test_download();
        test_overflow();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
